// File: rtl/bug_pkg.sv
// bug_pkg: shared types and constants for the bug game controller.
//   - bug_state_e : controller state encoding (MOVE / HIT / RESPAWN)
//   - default screen/bug geometry, reset position, LFSR seed and taps
//   - center_pos() : top-left coordinate that centres a box on an axis
//   - lfsr_next()  : one step of the 16-bit Fibonacci LFSR
package bug_pkg;

    typedef enum logic [1:0] {
        MOVE    = 2'd0,
        HIT     = 2'd1,
        RESPAWN = 2'd2
    } bug_state_e;

    localparam int POS_W     = 12;

    localparam int H_RES_DEF = 800;
    localparam int V_RES_DEF = 600;
    localparam int BUG_W_DEF = 64;
    localparam int BUG_H_DEF = 64;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [POS_W-1:0] center_pos(input int res, input int w);
        return POS_W'(res / 2 - w / 2);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    localparam logic [POS_W-1:0] X_RST_DEF = center_pos(H_RES_DEF, BUG_W_DEF);
    localparam logic [POS_W-1:0] Y_RST_DEF = center_pos(V_RES_DEF, BUG_H_DEF);

endpackage

// File: rtl/bug_axis_step.sv
// bug_axis_step: combinational next position / direction for one axis.
// Ports:
//   p_i     current top-left coordinate
//   dir_i   1 = moving towards limit_i, 0 = moving towards 0
//   limit_i largest legal coordinate on this axis
//   step_i  pixels moved per frame
//   p_o     next coordinate (clamped to [0, limit_i])
//   dir_o   next direction (flips when an edge is reached)
module bug_axis_step
    import bug_pkg::*;
(
    input  logic [POS_W-1:0] p_i,
    input  logic             dir_i,
    input  logic [POS_W-1:0] limit_i,
    input  logic [POS_W-1:0] step_i,
    output logic [POS_W-1:0] p_o,
    output logic             dir_o
);

    always_comb begin
        p_o   = p_i;
        dir_o = dir_i;
        if (dir_i) begin
            // Extra bit keeps the sum from wrapping near the top of the range.
            if (({1'b0, p_i} + {1'b0, step_i}) >= {1'b0, limit_i}) begin
                p_o   = limit_i;
                dir_o = 1'b0;
            end else begin
                p_o = p_i + step_i;
            end
        end else begin
            if (p_i <= step_i) begin
                p_o   = '0;
                dir_o = 1'b1;
            end else begin
                p_o = p_i - step_i;
            end
        end
    end

endmodule

// File: rtl/bug_ctl.sv
// bug_ctl: moves the bug sprite once per frame, bounces it off the screen
// edges, scores mouse-click hits and respawns the bug at an LFSR position.
// Ports (pclk domain, all outputs registered):
//   pclk, reset         clock, async active-high reset
//   vblnk_in            vertical blank; its rising edge is the frame tick
//   mouse_left          left button level
//   xpos_mouse/ypos_mouse  mouse position
//   x_bugpos/y_bugpos   bug top-left position
//   bug_visible         draw enable
//   score               saturating hit count
//   hit_pulse           one-cycle strobe per hit
//
// state   | meaning
// MOVE    | bug moves on each tick, clicks are hit-tested
// HIT     | bug frozen and blinking for HIT_FRAMES ticks, clicks ignored
// RESPAWN | one cycle: load random position/direction, then MOVE
module bug_ctl
    import bug_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int BUG_W      = BUG_W_DEF,
    parameter int BUG_H      = BUG_H_DEF,
    parameter int STEP       = 2,
    parameter int HIT_FRAMES = 30,
    parameter int SCORE_W    = 8
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               vblnk_in,
    input  logic               mouse_left,
    input  logic [11:0]        xpos_mouse,
    input  logic [11:0]        ypos_mouse,
    output logic [11:0]        x_bugpos,
    output logic [11:0]        y_bugpos,
    output logic               bug_visible,
    output logic [SCORE_W-1:0] score,
    output logic               hit_pulse
);

    localparam logic [POS_W-1:0] X_LIM  = POS_W'(H_RES - BUG_W);
    localparam logic [POS_W-1:0] Y_LIM  = POS_W'(V_RES - BUG_H);
    localparam logic [POS_W-1:0] X_RST  = center_pos(H_RES, BUG_W);
    localparam logic [POS_W-1:0] Y_RST  = center_pos(V_RES, BUG_H);
    localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);
    // At least 3 bits so the blink bit always exists.
    localparam int FC_W = ($clog2(HIT_FRAMES) < 3) ? 3 : $clog2(HIT_FRAMES);
    localparam logic [FC_W-1:0]    FRM_LAST  = FC_W'(HIT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    bug_state_e        state_q, state_d;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic              dx_q, dx_d, dy_q, dy_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic              vis_q, vis_d;
    logic              hit_q, hit_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              vblnk_q, mouse_left_q;

    logic              tick, click, in_box;
    logic [POS_W-1:0]  x_nxt, y_nxt;
    logic              dx_nxt, dy_nxt;
    logic [POS_W-1:0]  rx_raw, ry_raw, rx, ry;
    logic [POS_W:0]    x_end, y_end;

    bug_axis_step u_step_x (
        .p_i     (x_q),
        .dir_i   (dx_q),
        .limit_i (X_LIM),
        .step_i  (STEP_P),
        .p_o     (x_nxt),
        .dir_o   (dx_nxt)
    );

    bug_axis_step u_step_y (
        .p_i     (y_q),
        .dir_i   (dy_q),
        .limit_i (Y_LIM),
        .step_i  (STEP_P),
        .p_o     (y_nxt),
        .dir_o   (dy_nxt)
    );

    assign tick  = vblnk_in & ~vblnk_q;
    assign click = mouse_left & ~mouse_left_q;

    // Box end computed one bit wider; with legal geometry it never wraps.
    assign x_end  = {1'b0, x_q} + (POS_W+1)'(BUG_W);
    assign y_end  = {1'b0, y_q} + (POS_W+1)'(BUG_H);
    assign in_box = (xpos_mouse >= x_q) && ({1'b0, xpos_mouse} < x_end) &&
                    (ypos_mouse >= y_q) && ({1'b0, ypos_mouse} < y_end);

    // Fold the raw 10-bit LFSR fields back into the legal range.
    assign rx_raw = {2'b00, lfsr_q[9:0]};
    assign ry_raw = {2'b00, lfsr_q[15:6]};
    assign rx     = (rx_raw > X_LIM) ? rx_raw - X_LIM : rx_raw;
    assign ry     = (ry_raw > Y_LIM) ? ry_raw - Y_LIM : ry_raw;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        score_d = score_q;
        vis_d   = vis_q;
        hit_d   = 1'b0;
        fcnt_d  = fcnt_q;
        lfsr_d  = lfsr_next(lfsr_q);
        case (state_q)
            MOVE: begin
                vis_d = 1'b1;
                // A hit takes priority over a same-cycle move.
                if (click && in_box) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_ONE;
                    fcnt_d  = '0;
                    state_d = HIT;
                end else if (tick) begin
                    x_d  = x_nxt;
                    y_d  = y_nxt;
                    dx_d = dx_nxt;
                    dy_d = dy_nxt;
                end
            end
            HIT: begin
                if (tick) begin
                    if (fcnt_q == FRM_LAST) begin
                        state_d = RESPAWN;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                vis_d = ~fcnt_d[2];
            end
            RESPAWN: begin
                x_d     = rx;
                y_d     = ry;
                dx_d    = lfsr_q[0];
                dy_d    = lfsr_q[1];
                vis_d   = 1'b1;
                state_d = MOVE;
            end
            default: state_d = MOVE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q      <= MOVE;
            x_q          <= X_RST;
            y_q          <= Y_RST;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            score_q      <= '0;
            vis_q        <= 1'b1;
            hit_q        <= 1'b0;
            fcnt_q       <= '0;
            lfsr_q       <= LFSR_SEED;
            vblnk_q      <= 1'b0;
            mouse_left_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            score_q      <= score_d;
            vis_q        <= vis_d;
            hit_q        <= hit_d;
            fcnt_q       <= fcnt_d;
            lfsr_q       <= lfsr_d;
            vblnk_q      <= vblnk_in;
            mouse_left_q <= mouse_left;
        end
    end

    assign x_bugpos    = x_q;
    assign y_bugpos    = y_q;
    assign bug_visible = vis_q;
    assign score       = score_q;
    assign hit_pulse   = hit_q;

endmodule

// File: tb/tb_bug_ctl.sv
// tb_bug_ctl: directed self-checking bench for bug_ctl.
module tb_bug_ctl;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        vblnk_in = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] xpos_mouse = '0;
    logic [11:0] ypos_mouse = '0;
    logic [11:0] x_bugpos, y_bugpos;
    logic        bug_visible;
    logic [7:0]  score;
    logic        hit_pulse;

    int total = 0;
    int bad   = 0;
    logic p1, p2;

    bug_ctl dut (
        .pclk        (pclk),
        .reset       (reset),
        .vblnk_in    (vblnk_in),
        .mouse_left  (mouse_left),
        .xpos_mouse  (xpos_mouse),
        .ypos_mouse  (ypos_mouse),
        .x_bugpos    (x_bugpos),
        .y_bugpos    (y_bugpos),
        .bug_visible (bug_visible),
        .score       (score),
        .hit_pulse   (hit_pulse)
    );

    always #5 pclk = ~pclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        vblnk_in   = 1'b0;
        mouse_left = 1'b0;
        xpos_mouse = '0;
        ypos_mouse = '0;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    task automatic frame_tick();
        @(posedge pclk);
        #1 vblnk_in = 1'b1;
        @(posedge pclk);
        #1 vblnk_in = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    // p1: hit_pulse in the cycle after the press, p2: one cycle later.
    task automatic click_at(input logic [11:0] cx, input logic [11:0] cy,
                            output logic o1, output logic o2);
        @(posedge pclk);
        #1 xpos_mouse = cx;
        ypos_mouse = cy;
        mouse_left = 1'b1;
        @(posedge pclk);
        #1 o1 = hit_pulse;
        mouse_left = 1'b0;
        @(posedge pclk);
        #1 o2 = hit_pulse;
    endtask

    logic [11:0] bx [6] = '{12'd367, 12'd432, 12'd400, 12'd400, 12'd368, 12'd431};
    logic [11:0] by [6] = '{12'd300, 12'd300, 12'd267, 12'd332, 12'd268, 12'd331};
    logic        bh [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset values
        do_reset();
        check_val("rst_x", x_bugpos, 368);
        check_val("rst_y", y_bugpos, 268);
        check_val("rst_score", score, 0);
        check_val("rst_vis", bug_visible, 1);
        check_val("rst_hit", hit_pulse, 0);

        // 9 short ticks + one long vblank = 10 ticks
        ticks(9);
        @(posedge pclk);
        #1 vblnk_in = 1'b1;
        repeat (20) @(posedge pclk);
        #1 vblnk_in = 1'b0;
        check_val("t10_x", x_bugpos, 388);
        check_val("t10_y", y_bugpos, 288);
        repeat (5) @(posedge pclk);
        #1 check_val("idle_x", x_bugpos, 388);

        // Edge bounces
        ticks(124);
        check_val("t134_y", y_bugpos, 536);
        check_val("t134_x", x_bugpos, 636);
        ticks(1);
        check_val("t135_y", y_bugpos, 534);
        check_val("t135_x", x_bugpos, 638);
        ticks(49);
        check_val("t184_x", x_bugpos, 736);
        check_val("t184_y", y_bugpos, 436);
        ticks(1);
        check_val("t185_x", x_bugpos, 734);
        check_val("t185_y", y_bugpos, 434);
        ticks(217);
        check_val("t402_y", y_bugpos, 0);
        check_val("t402_x", x_bugpos, 300);
        ticks(1);
        check_val("t403_y", y_bugpos, 2);
        check_val("t403_x", x_bugpos, 298);

        // Hit, freeze, blink, respawn
        do_reset();
        click_at(12'd400, 12'd300, p1, p2);
        check_val("hit_p1", p1, 1);
        check_val("hit_p2", p2, 0);
        check_val("hit_score", score, 1);
        for (int k = 1; k <= 28; k++) begin
            frame_tick();
            check_val($sformatf("frz_x_%0d", k), x_bugpos, 368);
            check_val($sformatf("frz_y_%0d", k), y_bugpos, 268);
            check_val($sformatf("blink_%0d", k), bug_visible, ((k / 4) % 2 == 0) ? 1 : 0);
        end
        ticks(2);
        repeat (2) @(posedge pclk);
        #1;
        check_val("resp_vis", bug_visible, 1);
        check_val("resp_x_rng", (x_bugpos <= 12'd736) ? 1 : 0, 1);
        check_val("resp_y_rng", (y_bugpos <= 12'd536) ? 1 : 0, 1);
        check_val("resp_score", score, 1);
        click_at(x_bugpos, y_bugpos, p1, p2);
        check_val("resp_rehit", p1, 1);
        check_val("resp_score2", score, 2);

        // Boundary clicks
        for (int i = 0; i < 6; i++) begin
            do_reset();
            click_at(bx[i], by[i], p1, p2);
            check_val($sformatf("bnd_hit_%0d_%0d", bx[i], by[i]), p1, bh[i]);
            check_val($sformatf("bnd_score_%0d_%0d", bx[i], by[i]), score, bh[i] ? 1 : 0);
        end

        // Held button counts once; clicks during HIT ignored
        do_reset();
        @(posedge pclk);
        #1 xpos_mouse = 12'd400;
        ypos_mouse = 12'd300;
        mouse_left = 1'b1;
        ticks(3);
        mouse_left = 1'b0;
        check_val("held_score", score, 1);
        click_at(12'd400, 12'd300, p1, p2);
        check_val("hitst_pulse", p1, 0);
        check_val("hitst_score", score, 1);

        // Same-cycle click and tick: miss moves, hit freezes
        do_reset();
        @(posedge pclk);
        #1 vblnk_in = 1'b1;
        mouse_left = 1'b1;
        xpos_mouse = 12'd0;
        ypos_mouse = 12'd0;
        @(posedge pclk);
        #1 vblnk_in = 1'b0;
        mouse_left = 1'b0;
        check_val("ct_miss_x", x_bugpos, 370);
        check_val("ct_miss_score", score, 0);
        do_reset();
        @(posedge pclk);
        #1 vblnk_in = 1'b1;
        mouse_left = 1'b1;
        xpos_mouse = 12'd400;
        ypos_mouse = 12'd300;
        @(posedge pclk);
        #1 vblnk_in = 1'b0;
        mouse_left = 1'b0;
        check_val("ct_hit_pulse", hit_pulse, 1);
        check_val("ct_hit_x", x_bugpos, 368);
        check_val("ct_hit_score", score, 1);

        // Reset mid-HIT is immediate
        do_reset();
        click_at(12'd400, 12'd300, p1, p2);
        ticks(5);
        check_val("mid_vis_pre", bug_visible, 0);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_x", x_bugpos, 368);
        check_val("mid_rst_y", y_bugpos, 268);
        check_val("mid_rst_score", score, 0);
        check_val("mid_rst_vis", bug_visible, 1);
        check_val("mid_rst_hit", hit_pulse, 0);

        // Score saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            click_at(x_bugpos + 12'd1, y_bugpos + 12'd1, p1, p2);
            if (i == 254) check_val("sat_255", score, 255);
            ticks(30);
            repeat (2) @(posedge pclk);
            #1;
        end
        check_val("sat_last_pulse", p1, 1);
        check_val("sat_final", score, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
